// File: rtl/miller_rx_ctrl.sv
// Receive-frame sequencer for the PCD->PICC modified-Miller path: arms SoF/decoder,
// frames decoded bits into parity-checked bytes and closes the frame on EoF or timeout.
module miller_rx_ctrl #(
    parameter int ETU_CLKS    = 32,
    parameter int TIMEOUT_ETU = 4,
    parameter int CNT_W       = 6
) (
    input  logic             in_clk,
    input  logic             in_PoR,
    input  logic             in_rx_en,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic             in_bit_valid,
    input  logic             in_bit,
    output logic             out_sof_arm,
    output logic             out_dec_enable,
    output logic             out_sof_rearm,
    output logic [7:0]       out_byte,
    output logic             out_byte_valid,
    output logic [CNT_W-1:0] out_byte_cnt,
    output logic             out_parity_err,
    output logic             out_short_frame,
    output logic [3:0]       out_resid_bits,
    output logic             out_frame_done,
    output logic             out_timeout,
    output logic             out_busy
);

    // state     | meaning
    // S_IDLE    | reception disabled, all enables low
    // S_ARMED   | SoF detector armed, waiting for SoF rising edge
    // S_RECEIVE | decoder enabled, framing bits, inactivity timer running
    // S_DONE    | one cycle, frame closed by EoF
    // S_ERROR   | one cycle, frame aborted by inactivity timeout

    localparam int TO_CLKS = TIMEOUT_ETU * ETU_CLKS;
    localparam int TMR_W   = $clog2(TO_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TO_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RECEIVE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_nxt;
    logic               sof_q;
    logic               sof_edge;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [3:0]         pos, pos_nxt;
    logic [7:0]         shift, shift_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               perr_nxt;
    logic               short_nxt;
    logic [3:0]         resid_nxt;
    logic [7:0]         byte_nxt;
    logic               byte_valid_nxt;

    always_ff @(negedge in_clk or negedge in_PoR) begin
        if (!in_PoR) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        pos_nxt        = pos;
        shift_nxt      = shift;
        cnt_nxt        = out_byte_cnt;
        perr_nxt       = out_parity_err;
        short_nxt      = out_short_frame;
        resid_nxt      = out_resid_bits;
        byte_nxt       = out_byte;
        byte_valid_nxt = 1'b0;
        sof_edge       = in_sof & ~sof_q;

        unique case (state)
            S_IDLE: begin
                if (in_rx_en) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!in_rx_en) begin
                    state_nxt = S_IDLE;
                end else if (sof_edge) begin
                    state_nxt = S_RECEIVE;
                    timer_nxt = TMR_LOAD;
                    pos_nxt   = 4'd0;
                    shift_nxt = 8'h00;
                    cnt_nxt   = '0;
                    perr_nxt  = 1'b0;
                    short_nxt = 1'b0;
                    resid_nxt = 4'd0;
                end
            end
            S_RECEIVE: begin
                if (in_bit_valid) begin
                    timer_nxt = TMR_LOAD;
                    if (pos == 4'd8) begin
                        // odd parity: data bits plus parity bit must XOR to 1
                        pos_nxt        = 4'd0;
                        byte_nxt       = shift;
                        byte_valid_nxt = 1'b1;
                        if (out_byte_cnt != '1) cnt_nxt = out_byte_cnt + 1'b1;
                        if (!((^shift) ^ in_bit)) perr_nxt = 1'b1;
                    end else begin
                        shift_nxt[pos[2:0]] = in_bit;
                        pos_nxt             = pos + 4'd1;
                    end
                end else if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end

                // bit handling above runs first so EoF sees the updated position/count
                if (!in_rx_en) begin
                    state_nxt = S_IDLE;
                end else if (in_eof) begin
                    state_nxt = S_DONE;
                    if (cnt_nxt == '0 && pos_nxt == 4'd7) begin
                        byte_nxt       = {1'b0, shift_nxt[6:0]};
                        byte_valid_nxt = 1'b1;
                        short_nxt      = 1'b1;
                        resid_nxt      = 4'd0;
                    end else begin
                        resid_nxt = pos_nxt;
                    end
                end else if (!in_bit_valid && timer == '0) begin
                    state_nxt = S_ERROR;
                    resid_nxt = pos;
                end
            end
            S_DONE, S_ERROR: begin
                state_nxt = in_rx_en ? S_ARMED : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(negedge in_clk or negedge in_PoR) begin
        if (!in_PoR) begin
            sof_q           <= 1'b0;
            timer           <= '0;
            pos             <= 4'd0;
            shift           <= 8'h00;
            out_sof_arm     <= 1'b0;
            out_dec_enable  <= 1'b0;
            out_sof_rearm   <= 1'b0;
            out_byte        <= 8'h00;
            out_byte_valid  <= 1'b0;
            out_byte_cnt    <= '0;
            out_parity_err  <= 1'b0;
            out_short_frame <= 1'b0;
            out_resid_bits  <= 4'd0;
            out_frame_done  <= 1'b0;
            out_timeout     <= 1'b0;
            out_busy        <= 1'b0;
        end else begin
            sof_q           <= in_sof;
            timer           <= timer_nxt;
            pos             <= pos_nxt;
            shift           <= shift_nxt;
            out_sof_arm     <= (state_nxt == S_ARMED);
            out_dec_enable  <= (state_nxt == S_RECEIVE);
            out_busy        <= (state_nxt == S_RECEIVE);
            out_sof_rearm   <= (state_nxt == S_DONE) || (state_nxt == S_ERROR);
            out_frame_done  <= (state_nxt == S_DONE);
            out_timeout     <= (state_nxt == S_ERROR);
            out_byte        <= byte_nxt;
            out_byte_valid  <= byte_valid_nxt;
            out_byte_cnt    <= cnt_nxt;
            out_parity_err  <= perr_nxt;
            out_short_frame <= short_nxt;
            out_resid_bits  <= resid_nxt;
        end
    end

endmodule

// File: tb/tb_miller_rx_ctrl.sv
// Directed bench for miller_rx_ctrl: arm/disarm, byte framing, short frame,
// parity error, timeout, EoF coincident with parity bit and async reset mid-frame.
module tb_miller_rx_ctrl;

    logic       in_clk = 1'b0;
    logic       in_PoR;
    logic       in_rx_en;
    logic       in_sof;
    logic       in_eof;
    logic       in_bit_valid;
    logic       in_bit;
    logic       out_sof_arm;
    logic       out_dec_enable;
    logic       out_sof_rearm;
    logic [7:0] out_byte;
    logic       out_byte_valid;
    logic [5:0] out_byte_cnt;
    logic       out_parity_err;
    logic       out_short_frame;
    logic [3:0] out_resid_bits;
    logic       out_frame_done;
    logic       out_timeout;
    logic       out_busy;

    int errors = 0;
    int checks = 0;

    miller_rx_ctrl #(.ETU_CLKS(32), .TIMEOUT_ETU(4), .CNT_W(6)) dut (
        .in_clk          (in_clk),
        .in_PoR          (in_PoR),
        .in_rx_en        (in_rx_en),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .in_bit_valid    (in_bit_valid),
        .in_bit          (in_bit),
        .out_sof_arm     (out_sof_arm),
        .out_dec_enable  (out_dec_enable),
        .out_sof_rearm   (out_sof_rearm),
        .out_byte        (out_byte),
        .out_byte_valid  (out_byte_valid),
        .out_byte_cnt    (out_byte_cnt),
        .out_parity_err  (out_parity_err),
        .out_short_frame (out_short_frame),
        .out_resid_bits  (out_resid_bits),
        .out_frame_done  (out_frame_done),
        .out_timeout     (out_timeout),
        .out_busy        (out_busy)
    );

    always #5 in_clk = ~in_clk;

    // DUT acts on negedge; inputs change and outputs are sampled just after posedge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        in_bit       = b;
        in_bit_valid = 1'b1;
        cyc(1);
        in_bit_valid = 1'b0;
        in_bit       = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            strobe(d[i]);
            cyc(31);
        end
    endtask

    // raise SoF from ARMED (in_sof is low beforehand) and drop it again
    task automatic start_frame();
        in_sof = 1'b1;
        cyc(1);
        in_sof = 1'b0;
    endtask

    initial begin
        int  k;
        logic seen_done;

        in_PoR = 1'b0; in_rx_en = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_bit_valid = 1'b0; in_bit = 1'b0;
        cyc(2);
        chk("reset_outputs",
            {out_sof_arm, out_dec_enable, out_sof_rearm, out_byte, out_byte_valid, out_byte_cnt,
             out_parity_err, out_short_frame, out_resid_bits, out_frame_done, out_timeout, out_busy},
            32'h0);
        in_PoR = 1'b1;
        cyc(1);

        // arm, disarm, re-arm
        in_rx_en = 1'b1;
        cyc(1);
        chk("arm_sof_arm", out_sof_arm, 1'b1);
        chk("arm_others_low", {out_dec_enable, out_busy, out_frame_done, out_timeout}, 4'h0);
        in_rx_en = 1'b0;
        cyc(1);
        chk("disarm_sof_arm", out_sof_arm, 1'b0);
        in_rx_en = 1'b1;
        cyc(1);
        chk("rearm_sof_arm", out_sof_arm, 1'b1);

        // EoF and bit strobes outside RECEIVE are ignored
        in_eof = 1'b1; in_bit_valid = 1'b1; in_bit = 1'b1;
        cyc(1);
        in_eof = 1'b0; in_bit_valid = 1'b0; in_bit = 1'b0;
        chk("armed_eof_ignored", {out_frame_done, out_byte_valid, out_sof_arm}, 3'b001);

        // single byte 0xA5, parity 1
        start_frame();
        chk("sof_dec_enable", {out_dec_enable, out_busy, out_sof_arm}, 3'b110);
        send_bits(8'hA5, 8);
        strobe(1'b1);
        chk("a5_byte", out_byte, 8'hA5);
        chk("a5_valid", out_byte_valid, 1'b1);
        chk("a5_cnt", out_byte_cnt, 6'd1);
        chk("a5_perr", out_parity_err, 1'b0);
        cyc(1);
        chk("a5_valid_one_cycle", out_byte_valid, 1'b0);
        cyc(30);
        in_eof = 1'b1;
        cyc(1);
        in_eof = 1'b0;
        chk("a5_done", {out_frame_done, out_sof_rearm, out_busy, out_timeout}, 4'b1100);
        chk("a5_resid", out_resid_bits, 4'd0);
        chk("a5_short", out_short_frame, 1'b0);
        cyc(1);
        chk("a5_after_done", {out_frame_done, out_sof_rearm, out_sof_arm}, 3'b001);

        // short frame REQA 0x26
        start_frame();
        chk("reqa_cnt_cleared", out_byte_cnt, 6'd0);
        send_bits(8'h26, 7);
        in_eof = 1'b1;
        cyc(1);
        in_eof = 1'b0;
        chk("reqa_byte", out_byte, 8'h26);
        chk("reqa_flags", {out_byte_valid, out_short_frame, out_frame_done}, 3'b111);
        chk("reqa_cnt", out_byte_cnt, 6'd0);
        chk("reqa_resid", out_resid_bits, 4'd0);
        cyc(1);
        chk("reqa_hold", {out_short_frame, out_byte_valid, out_byte}, {1'b1, 1'b0, 8'h26});

        // parity error on second byte
        start_frame();
        chk("perr_short_cleared", out_short_frame, 1'b0);
        send_bits(8'h00, 8);
        strobe(1'b1);
        chk("perr_b0", {out_parity_err, out_byte_cnt}, {1'b0, 6'd1});
        cyc(31);
        send_bits(8'h01, 8);
        strobe(1'b1);
        chk("perr_b1", {out_parity_err, out_byte_cnt, out_byte}, {1'b1, 6'd2, 8'h01});
        cyc(31);
        in_eof = 1'b1;
        cyc(1);
        in_eof = 1'b0;
        chk("perr_done", {out_frame_done, out_parity_err, out_byte_cnt}, {1'b1, 1'b1, 6'd2});
        cyc(1);
        chk("perr_hold", out_parity_err, 1'b1);

        // inactivity timeout after 3 bits
        start_frame();
        chk("to_perr_cleared", out_parity_err, 1'b0);
        send_bits(8'h03, 2);
        strobe(1'b0);
        k = 0;
        seen_done = 1'b0;
        while (!out_timeout && k < 200) begin
            cyc(1);
            k++;
            if (out_frame_done) seen_done = 1'b1;
        end
        chk("to_latency", k, 129);
        chk("to_no_frame_done", seen_done, 1'b0);
        chk("to_resid", out_resid_bits, 4'd3);
        chk("to_rearm", out_sof_rearm, 1'b1);
        cyc(1);
        chk("to_back_armed", {out_timeout, out_sof_arm, out_busy}, 3'b010);

        // parity bit and EoF in the same cycle
        start_frame();
        send_bits(8'hFF, 8);
        in_eof = 1'b1;
        strobe(1'b1);
        in_eof = 1'b0;
        chk("sim_byte", {out_byte_valid, out_byte, out_byte_cnt}, {1'b1, 8'hFF, 6'd1});
        chk("sim_done", {out_frame_done, out_resid_bits, out_short_frame}, {1'b1, 4'd0, 1'b0});
        cyc(1);
        chk("sim_armed", {out_sof_arm, out_frame_done}, 2'b10);

        // async reset mid-byte
        start_frame();
        send_bits(8'h0F, 4);
        #1 in_PoR = 1'b0;
        #1;
        chk("por_outputs",
            {out_sof_arm, out_dec_enable, out_sof_rearm, out_byte, out_byte_valid, out_byte_cnt,
             out_parity_err, out_short_frame, out_resid_bits, out_frame_done, out_timeout, out_busy},
            32'h0);
        cyc(2);
        in_PoR = 1'b1;
        cyc(1);
        chk("por_recover_arm", out_sof_arm, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
